// File: rtl/armleo_cpu_tlb.sv
// armleo_cpu_tlb: set-associative TLB for the ArmleoCPU MMU.
// Caches VPN -> (ptag, metadata) translations; one RESOLVE / NEW_ENTRY /
// INVALIDATE_ALL command per clock. Fills use one global round-robin way pointer.
// Optional debug trace: define ARMLEOCPU_TLB_DEBUG_EN to print every command
// (simulation only, no functional effect).
module armleo_cpu_tlb #(
    parameter int ENTRIES_W   = 1,
    parameter int WAYS        = 3,
    parameter int INSTANCE_ID = 0,
    localparam int WAYS_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cmd,
    input  logic [19:0]       vaddr_input,
    input  logic [7:0]        new_entry_metadata_input,
    input  logic [21:0]       new_entry_ptag_input,
    output logic              hit,
    output logic [7:0]        resolve_metadata_output,
    output logic [21:0]       resolve_ptag_output,
    output logic [WAYS_W-1:0] resolve_way
);

    localparam int SETS  = 1 << ENTRIES_W;
    localparam int TAG_W = 20 - ENTRIES_W;

    typedef enum logic [1:0] {
        TLB_CMD_NONE           = 2'd0,
        TLB_CMD_RESOLVE        = 2'd1,
        TLB_CMD_NEW_ENTRY      = 2'd2,
        TLB_CMD_INVALIDATE_ALL = 2'd3
    } tlb_cmd_t;

    // Per-set, per-way storage. Only the valid bits carry reset state.
    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] vtag_q  [SETS][WAYS];
    logic [21:0]      ptag_q  [SETS][WAYS];
    logic [7:0]       meta_q  [SETS][WAYS];

    logic [WAYS_W-1:0] ptr_q;
    logic [WAYS_W-1:0] ptr_next;

    logic [ENTRIES_W-1:0] set_idx;
    logic [TAG_W-1:0]     vtag;

    logic              lookup_hit;
    logic [WAYS_W-1:0] lookup_way;
    logic [21:0]       lookup_ptag;
    logic [7:0]        lookup_meta;

    tlb_cmd_t cmd_e;

    assign cmd_e   = tlb_cmd_t'(cmd);
    assign set_idx = vaddr_input[ENTRIES_W-1:0];
    assign vtag    = vaddr_input[19:ENTRIES_W];

    // Round-robin pointer successor, wrapping from WAYS-1 back to 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ptr_next = ptr_q + 1'b1;
        if (ptr_q == WAYS_W'(WAYS - 1)) begin
            ptr_next = '0;
        end
    end

    // Tag compare across the indexed set; scanning downward lets the lowest
    // matching way overwrite any higher one, so duplicates resolve to it.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_way  = '0;
        lookup_ptag = '0;
        lookup_meta = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && (vtag_q[set_idx][w] == vtag)) begin
                lookup_hit  = 1'b1;
                lookup_way  = WAYS_W'(w);
                lookup_ptag = ptag_q[set_idx][w];
                lookup_meta = meta_q[set_idx][w];
            end
        end
    end

    // Control state: valid bits, replacement pointer and registered lookup result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
            ptr_q                   <= '0;
            hit                     <= 1'b0;
            resolve_metadata_output <= '0;
            resolve_ptag_output     <= '0;
            resolve_way             <= '0;
        end else begin
            case (cmd_e)
                TLB_CMD_RESOLVE: begin
                    hit                     <= lookup_hit;
                    resolve_metadata_output <= lookup_meta;
                    resolve_ptag_output     <= lookup_ptag;
                    resolve_way             <= lookup_way;
                end
                TLB_CMD_NEW_ENTRY: begin
                    valid_q[set_idx][ptr_q] <= 1'b1;
                    ptr_q                   <= ptr_next;
                end
                TLB_CMD_INVALIDATE_ALL: begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_q[s] <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Entry payload written on fill.
    always_ff @(posedge clk) begin
        // NOTE: the tag/data arrays are deliberately not reset; they are
        // unobservable until their valid bit is set, and leaving them out of
        // reset lets them map onto plain RAM.
        if (!rst && (cmd_e == TLB_CMD_NEW_ENTRY)) begin
            vtag_q[set_idx][ptr_q] <= vtag;
            ptag_q[set_idx][ptr_q] <= new_entry_ptag_input;
            meta_q[set_idx][ptr_q] <= new_entry_metadata_input;
        end
    end

`ifdef ARMLEOCPU_TLB_DEBUG_EN
    logic resolve_print_q;

    // Debug trace: one message per command, RESOLVE results once visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            resolve_print_q <= 1'b0;
        end else begin
            resolve_print_q <= (cmd_e == TLB_CMD_RESOLVE);
            if (resolve_print_q) begin
                $display("[armleo_cpu_tlb %0d] RESOLVE result hit=%0b ptag=0x%06h meta=0x%02h way=%0d",
                         INSTANCE_ID, hit, resolve_ptag_output, resolve_metadata_output, resolve_way);
            end
            case (cmd_e)
                TLB_CMD_RESOLVE: begin
                    $display("[armleo_cpu_tlb %0d] RESOLVE vaddr=0x%05h", INSTANCE_ID, vaddr_input);
                end
                TLB_CMD_NEW_ENTRY: begin
                    $display("[armleo_cpu_tlb %0d] NEW_ENTRY vaddr=0x%05h set=%0d way=%0d ptag=0x%06h meta=0x%02h",
                             INSTANCE_ID, vaddr_input, set_idx, ptr_q,
                             new_entry_ptag_input, new_entry_metadata_input);
                end
                TLB_CMD_INVALIDATE_ALL: begin
                    $display("[armleo_cpu_tlb %0d] INVALIDATE_ALL vaddr=0x%05h", INSTANCE_ID, vaddr_input);
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_armleo_cpu_tlb.sv
// tb_armleo_cpu_tlb: directed self-checking bench for armleo_cpu_tlb
// (ENTRIES_W=1, WAYS=3) with hand-computed expected values.
module tb_armleo_cpu_tlb;

    localparam logic [1:0] CMD_NONE    = 2'd0;
    localparam logic [1:0] CMD_RESOLVE = 2'd1;
    localparam logic [1:0] CMD_NEW     = 2'd2;
    localparam logic [1:0] CMD_INV     = 2'd3;

    logic        clk;
    logic        rst;
    logic [1:0]  cmd;
    logic [19:0] vaddr_input;
    logic [7:0]  new_entry_metadata_input;
    logic [21:0] new_entry_ptag_input;
    logic        hit;
    logic [7:0]  resolve_metadata_output;
    logic [21:0] resolve_ptag_output;
    logic [1:0]  resolve_way;

    int checks   = 0;
    int failures = 0;

    armleo_cpu_tlb #(
        .ENTRIES_W  (1),
        .WAYS       (3),
        .INSTANCE_ID(0)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cmd                     (cmd),
        .vaddr_input             (vaddr_input),
        .new_entry_metadata_input(new_entry_metadata_input),
        .new_entry_ptag_input    (new_entry_ptag_input),
        .hit                     (hit),
        .resolve_metadata_output (resolve_metadata_output),
        .resolve_ptag_output     (resolve_ptag_output),
        .resolve_way             (resolve_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_hit, input logic [21:0] e_ptag,
                             input logic [7:0] e_meta, input logic [1:0] e_way);
        check({tag, ".hit"},  32'(hit),                     32'(e_hit));
        check({tag, ".ptag"}, 32'(resolve_ptag_output),     32'(e_ptag));
        check({tag, ".meta"}, 32'(resolve_metadata_output), 32'(e_meta));
        check({tag, ".way"},  32'(resolve_way),             32'(e_way));
    endtask

    // Drive one command for exactly one rising edge, then sample #1 after it.
    task automatic issue(input logic [1:0] c, input logic [19:0] va,
                         input logic [7:0] meta, input logic [21:0] ptag);
        @(negedge clk);
        cmd                      = c;
        vaddr_input              = va;
        new_entry_metadata_input = meta;
        new_entry_ptag_input     = ptag;
        @(posedge clk);
        #1;
        cmd = CMD_NONE;
    endtask

    task automatic fill(input logic [19:0] va, input logic [7:0] meta, input logic [21:0] ptag);
        issue(CMD_NEW, va, meta, ptag);
    endtask

    task automatic resolve(input logic [19:0] va);
        issue(CMD_RESOLVE, va, 8'h00, 22'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd = CMD_RESOLVE;  // reset must win over a concurrent command
        vaddr_input = 20'h101;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd = CMD_NONE;
    endtask

    initial begin
        rst                      = 1'b1;
        cmd                      = CMD_NONE;
        vaddr_input              = '0;
        new_entry_metadata_input = '0;
        new_entry_ptag_input     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 22'h0, 8'h00, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: invalidate then miss
        issue(CMD_INV, 20'h0, 8'h00, 22'h0);
        resolve(20'h55);
        check_out("s1_miss55", 1'b0, 22'h0, 8'h00, 2'd0);

        // 2: four fills land in ways 0,1,2,0
        fill(20'h100, 8'hFF, 22'hF5);
        fill(20'h101, 8'h0F, 22'hF1);
        fill(20'h55,  8'hFF, 22'hFE);
        fill(20'h56,  8'hFF, 22'hF5);
        resolve(20'h55);
        check_out("s2_hit55", 1'b1, 22'hFE, 8'hFF, 2'd2);
        resolve(20'h56);
        check_out("s2_hit56", 1'b1, 22'hF5, 8'hFF, 2'd0);

        // 3: eviction of 0x100, 0x101 intact
        resolve(20'h100);
        check_out("s3_miss100", 1'b0, 22'h0, 8'h00, 2'd0);
        resolve(20'h101);
        check_out("s3_hit101", 1'b1, 22'hF1, 8'h0F, 2'd1);

        // 4: invalidate keeps outputs and pointer
        issue(CMD_INV, 20'h0, 8'h00, 22'h0);
        check_out("s4_inv_hold", 1'b1, 22'hF1, 8'h0F, 2'd1);
        resolve(20'h55);
        check("s4_miss55", 32'(hit), 32'd0);
        resolve(20'h56);
        check("s4_miss56", 32'(hit), 32'd0);
        resolve(20'h100);
        check("s4_miss100", 32'(hit), 32'd0);
        resolve(20'h101);
        check_out("s4_miss101", 1'b0, 22'h0, 8'h00, 2'd0);
        fill(20'h101, 8'h0F, 22'hF1);
        check_out("s4_fill_hold", 1'b0, 22'h0, 8'h00, 2'd0);
        resolve(20'h101);
        check_out("s4_refill_way1", 1'b1, 22'hF1, 8'h0F, 2'd1);

        // 5: hold across NONE, then reset mid-sequence
        resolve(20'h101);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("s5_hold%0d.hit", i), 32'(hit), 32'd1);
            check($sformatf("s5_hold%0d.ptag", i), 32'(resolve_ptag_output), 32'hF1);
        end
        pulse_reset();
        check_out("s5_reset", 1'b0, 22'h0, 8'h00, 2'd0);
        resolve(20'h101);
        check_out("s5_after_rst101", 1'b0, 22'h0, 8'h00, 2'd0);
        resolve(20'h56);
        check("s5_after_rst56", 32'(hit), 32'd0);

        // 6: pointer restarted at 0; duplicate 0x57 in ways 1 and 2
        fill(20'h58, 8'hA5, 22'h3ABCDE);
        fill(20'h57, 8'h11, 22'h111111);
        fill(20'h57, 8'h22, 22'h222222);
        resolve(20'h58);
        check_out("s6_hit58", 1'b1, 22'h3ABCDE, 8'hA5, 2'd0);
        resolve(20'h57);
        check_out("s6_dup57", 1'b1, 22'h111111, 8'h11, 2'd1);
        // tag match in the wrong set must miss (0x56 is set 0, 0x57 lives in set 1)
        resolve(20'h56);
        check("s6_miss56", 32'(hit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
